// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Brief    : Programmable serial pattern-detect controller. Holds a run-time
//             pattern (1..MAX_LEN bits), paces a serial stream with
//             ready/valid, counts matches and ends a run on a match target
//             or a no-match timeout.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    parameter  int TO_W    = 10,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               detect,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [TO_W-1:0]  c_to_max  = {TO_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [MAX_LEN-1:0] r_shift;
    logic [LEN_W-1:0]   r_fill;
    logic [TO_W-1:0]    r_to;
    logic [CNT_W-1:0]   r_count;
    logic               r_timed_out;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_shift_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [TO_W-1:0]    w_to_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_timeout;
    logic [LEN_W-1:0]   w_len_clamped;

    // Next-value datapath for an accepted bit plus the match/timeout decision.
    always_comb begin
        w_accept    = in_valid && (r_state == S_ARMED);
        w_shift_nxt = {r_shift[MAX_LEN-2:0], in_bit};
        w_fill_nxt  = (r_fill >= r_len) ? r_len : (r_fill + c_len_one);
        w_to_nxt    = r_to + TO_W'(1);
        w_mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_match   = (w_fill_nxt == r_len) &&
                    (((w_shift_nxt ^ r_pattern) & w_mask) == '0);
        w_timeout = (w_to_nxt == c_to_max);
        // Length 0 is meaningless, lengths beyond the shift register cannot match.
        if (cfg_len == '0)
            w_len_clamped = c_len_one;
        else if (cfg_len > c_len_max)
            w_len_clamped = c_len_max;
        else
            w_len_clamped = cfg_len;
    end

    // Run sequencer with configuration, shift/fill/timeout and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pattern   <= '0;
            r_len       <= c_len_one;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_shift     <= '0;
            r_fill      <= '0;
            r_to        <= '0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && cfg_we) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_len_clamped;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
            end
            // stop overrides every other transition, including a same-cycle start.
            if (stop) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state     <= S_ARMED;
                            r_shift     <= '0;
                            r_fill      <= '0;
                            r_to        <= '0;
                            r_count     <= '0;
                            r_timed_out <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (w_accept) begin
                            r_shift <= w_shift_nxt;
                            if (w_match) begin
                                // A match beats a timeout landing on the same bit.
                                r_state <= S_MATCH;
                                r_to    <= '0;
                                r_fill  <= r_overlap ? w_fill_nxt : '0;
                                if (r_count != c_cnt_max)
                                    r_count <= r_count + CNT_W'(1);
                            end else begin
                                r_fill <= w_fill_nxt;
                                r_to   <= w_to_nxt;
                                if (w_timeout) begin
                                    r_state     <= S_DONE;
                                    r_timed_out <= 1'b1;
                                end
                            end
                        end
                    end
                    S_MATCH: begin
                        // r_count already includes the match that got us here.
                        if ((r_target != '0) && (r_count == r_target))
                            r_state <= S_DONE;
                        else
                            r_state <= S_ARMED;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready    = (r_state == S_ARMED);
    assign detect      = (r_state == S_MATCH);
    assign busy        = (r_state == S_ARMED) || (r_state == S_MATCH);
    assign done        = (r_state == S_DONE);
    assign timed_out   = r_timed_out;
    assign match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_ctrl
//  Brief    : Directed self-checking bench for seq_detect_ctrl with a
//             match scoreboard fed by a small pattern model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 4;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               in_valid;
    logic               in_bit;
    logic               in_ready;
    logic               detect;
    logic               busy;
    logic               done;
    logic               timed_out;
    logic [CNT_W-1:0]   match_count;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected match_count value for each detect pulse.
    logic [CNT_W-1:0] q_exp[$];

    // Reference model of the pattern matcher.
    logic [7:0] m_shift;
    logic [7:0] m_pat;
    int         m_fill;
    int         m_len;
    bit         m_over;
    int         m_count;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .TO_W    (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .detect      (detect),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every detect pulse must correspond to a queued expected match.
    always @(negedge clk) begin
        if (reset === 1'b0 && detect === 1'b1) begin
            if (q_exp.size() == 0)
                check("unexpected_detect", 32'(detect), 32'd0);
            else
                check("detect_count", 32'(match_count), 32'(q_exp.pop_front()));
        end
    end

    function automatic void model_accept(input logic b);
        logic [7:0] mask;
        m_shift = {m_shift[6:0], b};
        m_fill  = (m_fill + 1 > m_len) ? m_len : m_fill + 1;
        mask    = '0;
        for (int i = 0; i < 8; i++)
            if (i < m_len) mask[i] = 1'b1;
        if (m_fill == m_len && ((m_shift ^ m_pat) & mask) == 8'd0) begin
            if (m_count < 255) m_count++;
            q_exp.push_back(CNT_W'(m_count));
            if (!m_over) m_fill = 0;
        end
    endfunction

    task automatic pulse_ctrl(input logic st, input logic sp);
        @(negedge clk);
        start = st;
        stop  = sp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic configure(input logic [7:0] pat, input int len, input logic over,
                             input logic [7:0] tgt);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = over;
        cfg_target  = tgt;
        cfg_we      = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        m_pat  = pat;
        m_len  = (len == 0) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
        m_over = over;
    endtask

    task automatic arm();
        pulse_ctrl(1'b1, 1'b0);
        m_shift = '0;
        m_fill  = 0;
        m_count = 0;
    endtask

    // Offer one bit and hold it until it is taken (bounded wait).
    task automatic send_bit(input logic b);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
        if (in_ready === 1'b1) begin
            in_valid = 1'b1;
            in_bit   = b;
            model_accept(b);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        check("pending_detects", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        m_shift = '0; m_pat = '0; m_fill = 0; m_len = 1; m_over = 0; m_count = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_detect", 32'(detect), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Overlapping run: 1111 against 11 gives three matches.
        configure(8'b11, 2, 1'b1, 8'd0);
        arm();
        check("armed_ready", 32'(in_ready), 32'd1);
        send_bits(16'b1111, 4);
        settle();
        check("ovl_count", 32'(match_count), 32'd3);
        check("ovl_busy", 32'(busy), 32'd1);
        pulse_ctrl(1'b0, 1'b1);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_keeps_count", 32'(match_count), 32'd3);

        // Non-overlapping run: same stream gives two matches.
        configure(8'b11, 2, 1'b0, 8'd0);
        arm();
        check("arm_clears_count", 32'(match_count), 32'd0);
        send_bits(16'b1111, 4);
        settle();
        check("novl_count", 32'(match_count), 32'd2);
        pulse_ctrl(1'b0, 1'b1);

        // Target of two matches ends the run; further bits are refused.
        configure(8'b101, 3, 1'b1, 8'd2);
        arm();
        send_bits(16'b10101, 5);
        settle();
        check("tgt_done", 32'(done), 32'd1);
        check("tgt_ready", 32'(in_ready), 32'd0);
        check("tgt_count", 32'(match_count), 32'd2);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("tgt_hold_count", 32'(match_count), 32'd2);
        check("tgt_hold_done", 32'(done), 32'd1);
        arm();
        check("rearm_count", 32'(match_count), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
        check("rearm_ready", 32'(in_ready), 32'd1);
        check("rearm_done", 32'(done), 32'd0);
        send_bits(16'b10101, 5);
        settle();
        check("tgt2_done", 32'(done), 32'd1);
        pulse_ctrl(1'b1, 1'b1);
        check("startstop_done", 32'(done), 32'd0);
        check("startstop_busy", 32'(busy), 32'd0);

        // Timeout: 15 non-matching bits end the run.
        configure(8'b1111, 4, 1'b0, 8'd0);
        arm();
        send_bits(16'h0000, 15);
        settle();
        check("to_done", 32'(done), 32'd1);
        check("to_flag", 32'(timed_out), 32'd1);
        check("to_count", 32'(match_count), 32'd0);
        pulse_ctrl(1'b0, 1'b1);
        arm();
        check("to_flag_cleared", 32'(timed_out), 32'd0);
        // The 15th bit both completes a match and would expire the counter.
        send_bits(16'b000_0000_0000_1111, 15);
        settle();
        check("to_match_flag", 32'(timed_out), 32'd0);
        check("to_match_busy", 32'(busy), 32'd1);
        check("to_match_count", 32'(match_count), 32'd1);
        pulse_ctrl(1'b0, 1'b1);

        // Configuration writes while armed are ignored.
        configure(8'b11, 2, 1'b1, 8'd0);
        arm();
        @(negedge clk);
        cfg_pattern = 8'b00;
        cfg_we      = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        send_bits(16'b11, 2);
        settle();
        check("cfgwe_armed_count", 32'(match_count), 32'd1);
        pulse_ctrl(1'b0, 1'b1);

        // Length 0 is treated as length 1.
        configure(8'b1, 0, 1'b0, 8'd0);
        arm();
        send_bits(16'b1011, 4);
        settle();
        check("len0_count", 32'(match_count), 32'd3);

        // Reset while in MATCH.
        send_bit(1'b1);
        check("mid_detect", 32'(detect), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_detect", 32'(detect), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(match_count), 32'd0);
        q_exp.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd0);
        // Reset configuration is pattern 0, length 1: a single 0 matches.
        m_pat = '0; m_len = 1; m_over = 0;
        arm();
        send_bit(1'b0);
        settle();
        check("post_rst_cfg_count", 32'(match_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detect controller for the bit-stream detector path. Holds a run-time configured pattern (1..MAX_LEN bits), arms and disarms detection on command, and paces input with a ready/valid handshake. Counts matches and ends a run on a match target or a no-match timeout. A Moore FSM sequences the run; status is read by the surrounding control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of match_count and cfg_target
TO_W, 10, width of timeout bit counter; timeout fires after 2**TO_W-1 accepted bits without a match

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  load configuration; honoured only in IDLE
cfg_pattern  input  MAX_LEN  pattern; LSB = most recent bit
cfg_len  input  clog2(MAX_LEN)+1  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches that end a run; 0 = unlimited
start  input  1  arm or re-arm (pulse)
stop  input  1  abort to IDLE (pulse)
in_valid  input  1  serial bit valid
in_bit  input  1  serial data bit
in_ready  output  1  high only in ARMED
detect  output  1  one-cycle match pulse, decoded from state
busy  output  1  high in ARMED or MATCH
done  output  1  high in DONE
timed_out  output  1  last run ended on timeout
match_count  output  CNT_W  matches in current or last run, saturating

Behaviour:
- Reset (async): state IDLE; all outputs 0; pattern reg 0; len reg 1; overlap 0; target 0; shift reg, fill and timeout counters 0.
- Length clamp at load: cfg_len 0 stored as 1; cfg_len > MAX_LEN stored as MAX_LEN.
- States: IDLE, ARMED, MATCH, DONE. All outputs are registered state decodes or registers. No combinational path from inputs to outputs.
- IDLE: cfg_we captures all cfg_* fields. On start: go to ARMED; clear shift reg, fill, timeout counter, match_count and timed_out.
- ARMED:
  - A bit is accepted when in_valid && in_ready.
  - On accept: shift reg shifts left with in_bit entering the LSB; fill <= min(fill+1, len); timeout counter +1.
  - Match condition: updated fill == len and the low len bits of the updated shift reg equal the low len bits of the pattern.
  - On match: go to MATCH; match_count +1, saturating at all-ones; timeout counter cleared; if overlap = 0, fill cleared to 0.
  - Otherwise, if the timeout counter reaches all-ones: go to DONE with timed_out = 1.
  - Match and timeout on the same bit: match wins.
- MATCH: lasts exactly one cycle. detect = 1 and in_ready = 0, so no bit is accepted. Next state is DONE if target != 0 and match_count == target, otherwise ARMED.
- Latency: detect asserts the cycle after the completing bit is accepted. Maximum throughput is one bit every 2 cycles while matches occur back to back.
- DONE: done held high, in_ready 0, match_count and timed_out held. start re-arms exactly as from IDLE. stop goes to IDLE.
- stop in any state: IDLE next cycle; match_count and timed_out retained.
- stop and start in the same cycle: stop wins.
- start in ARMED or MATCH: ignored.
- cfg_we outside IDLE: ignored.
- reset mid-run: immediate return to the reset values above.

Test Plan:
- Overlapping run: cfg pattern=0b11, len=2, overlap=1, target=0; start; bits 1,1,1,1 each accepted when in_ready is high -> detect pulses 3 times, match_count=3, busy=1.
- Non-overlapping run: same stream with overlap=0 -> detect pulses 2 times, match_count=2.
- Target stop and re-arm: pattern=0b101, len=3, target=2; stream 1,0,1,0,1,0,1 -> done=1 after the second match, in_ready=0, and remaining bits are not accepted. start -> match_count=0, state ARMED.
- Timeout with TO_W=4: pattern=0b1111, len=4; 15 zeros -> done=1, timed_out=1, match_count=0. Then a second case where the 15th accepted bit completes a match -> MATCH taken, timed_out=0.
- Control corner cases: cfg_we while ARMED -> pattern unchanged. start and stop in the same cycle -> IDLE. cfg_len=0 -> behaves as length 1, so every 1-bit matching the pattern LSB pulses detect.
- Reset mid-run: assert reset in MATCH -> detect, busy and match_count are 0 immediately, and state is IDLE after release.
